instr_seq_ctrl: RTL and testbench
=================================

Name: instr_seq_ctrl

Overview:
Multi-cycle sequencer for the 8-bit processor datapath (register file, 2's-complement/immediate muxes, ALU). Owns the program counter and fetches 32-bit instructions from an instruction memory over a req/ack handshake. Decodes the opcode and drives the datapath controls, including a one-cycle register-file write strobe per instruction. Sits between instruction memory and the Processor datapath and replaces the free-running counter/IR pair.

Parameters:
RESET_PC, 32'd0, PC value loaded on reset and on restart.
PC_STEP, 32'd4, PC increment per retired instruction.
FETCH_TIMEOUT, 16, max cycles imem_req may wait for imem_ack before error.
CNT_W, 16, width of retired-instruction counter.

Ports:
clk  input  1  system clock, all state on rising edge.
reset  input  1  asynchronous, active-low reset (asserted when 0).
run  input  1  level; 1 = sequencer may fetch, 0 = pause at next instruction boundary.
imem_addr  output  32  fetch address (= PC).
imem_req  output  1  fetch request, held until ack.
imem_ack  input  1  one-cycle ack; imem_rdata valid in same cycle.
imem_rdata  input  32  instruction word.
instr  output  32  latched instruction to datapath (dest [18:16], src2 [10:8], src1/imm [7:0]).
alu_sel  output  3  ALU select = instr[26:24].
sub_en  output  1  selects negated operand (opcode 0x09).
imm_sel  output  1  0 = immediate path (opcode 0x00), 1 = register path.
rf_wen  output  1  register-file write strobe, one cycle per instruction.
halted  output  1  sequencer in HALT.
err  output  1  sticky: illegal opcode or fetch timeout.
retired  output  CNT_W  count of instructions written back, wraps.

Behaviour:
- Reset (reset=0, async): state=IDLE, PC=RESET_PC, instr=0, imem_req=0, rf_wen=0, sub_en=0, imm_sel=1, alu_sel=0, halted=0, err=0, retired=0, timeout counter=0.
- States: IDLE, FETCH, DECODE, EXEC, WB, HALT.
- IDLE: if run=1 -> FETCH next cycle; else stay.
- FETCH: imem_req=1, imem_addr=PC. On imem_ack=1: instr<=imem_rdata, imem_req drops next cycle, -> DECODE. Timeout counter increments each FETCH cycle without ack; reaching FETCH_TIMEOUT -> err=1, HALT. Counter clears on entering FETCH.
- DECODE: legal opcodes instr[31:24] in {0x00 loadi, 0x01 add, 0x02 and, 0x03 or, 0x08 mov, 0x09 sub}; 0xFF = halt -> HALT, err unchanged; any other opcode -> err=1, HALT. Legal -> EXEC; alu_sel/sub_en/imm_sel registered here, stable through EXEC and WB.
- EXEC: one cycle for ALU settle, rf_wen=0 -> WB.
- WB: rf_wen=1 for exactly this cycle; PC<=PC+PC_STEP (mod 2^32, wrap from 0xFFFFFFFC to 0); retired<=retired+1 (wraps). Next: FETCH if run=1, else IDLE.
- Latency: 4 cycles per instruction with zero-wait ack (FETCH, DECODE, EXEC, WB); each extra ack wait adds one cycle.
- run deasserted mid-instruction: current instruction completes through WB, then IDLE. PC holds.
- HALT: all strobes 0, imem_req=0, halted=1; exits only via reset. PC frozen at halting instruction address.
- imem_ack while not in FETCH: ignored.
- Reset mid-fetch: imem_req drops immediately (async); a late ack after reset release is ignored.
- Outputs registered; none combinational from inputs.

Test Plan:
- Reset, run=1, zero-wait memory with program loadi r4,0xFF; loadi r6,0xAA; add r5,r6,r3 -> imem_addr 0,4,8; rf_wen pulses at cycles 4, 8, 12 after run; retired=3; imm_sel=0 for loadi, 1 for add.
- sub 4,7,3 (0x0904_0F03) -> sub_en=1, alu_sel=3'b001, one rf_wen pulse, PC += 4.
- ack delayed 3 cycles on the second fetch -> imem_req held 4 cycles; instruction latency 7; no extra rf_wen.
- opcode 0x05 at PC=8 -> err=1, halted=1, PC stays 8, no rf_wen; opcode 0xFF -> halted=1, err=0.
- no ack for 16 cycles -> err=1, halted=1, imem_req=0; then reset=0 pulse -> all outputs at reset values, PC=0.
- run dropped during EXEC -> WB completes (rf_wen=1, retired+1), then IDLE with imem_req=0; run=1 resumes fetch at next PC.

Source files
------------

// File: rtl/instr_seq_ctrl.sv
// instr_seq_ctrl: multi-cycle fetch/decode/exec/writeback sequencer
// for the 8-bit datapath. It owns the PC and the instruction register.
//
// Ports:
//   clk        : system clock, all state updates on the rising edge
//   reset      : asynchronous active-low reset
//   run        : 1 = fetch allowed, 0 = pause at next instruction boundary
//   imem_addr  : fetch address (current PC)
//   imem_req   : fetch request, held until imem_ack
//   imem_ack   : one-cycle ack, imem_rdata valid in the same cycle
//   imem_rdata : instruction word from memory
//   instr      : latched instruction driven to the datapath
//   alu_sel    : ALU select (instr[26:24])
//   sub_en     : negated second operand (sub)
//   imm_sel    : 0 = immediate path (loadi), 1 = register path
//   rf_wen     : register-file write strobe, one cycle per instruction
//   halted     : sequencer parked in HALT
//   err        : sticky illegal-opcode / fetch-timeout flag
//   retired    : wrapping count of written-back instructions
module instr_seq_ctrl #(
    parameter logic [31:0] RESET_PC      = 32'd0,
    parameter logic [31:0] PC_STEP       = 32'd4,
    parameter int          FETCH_TIMEOUT = 16,
    parameter int          CNT_W         = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    output logic [31:0]      imem_addr,
    output logic             imem_req,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      instr,
    output logic [2:0]       alu_sel,
    output logic             sub_en,
    output logic             imm_sel,
    output logic             rf_wen,
    output logic             halted,
    output logic             err,
    output logic [CNT_W-1:0] retired
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [7:0] OP_LOADI = 8'h00;
    localparam logic [7:0] OP_ADD   = 8'h01;
    localparam logic [7:0] OP_AND   = 8'h02;
    localparam logic [7:0] OP_OR    = 8'h03;
    localparam logic [7:0] OP_MOV   = 8'h08;
    localparam logic [7:0] OP_SUB   = 8'h09;
    localparam logic [7:0] OP_HALT  = 8'hFF;

    localparam int TO_W = $clog2(FETCH_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(FETCH_TIMEOUT - 1);

    logic [2:0]       r_state;
    logic [31:0]      r_pc;
    logic [31:0]      r_instr;
    logic             r_req;
    logic             r_wen;
    logic [2:0]       r_alu;
    logic             r_sub;
    logic             r_imm;
    logic             r_halt;
    logic             r_err;
    logic [CNT_W-1:0] r_ret;
    logic [TO_W-1:0]  r_to;

    logic [2:0]       w_next;
    logic [7:0]       w_op;
    logic             w_legal;
    logic             w_is_halt;
    logic             w_fetch_ack;
    logic             w_to_hit;
    logic             w_set_err;

    assign w_op        = r_instr[31:24];
    // ack outside FETCH is deliberately ignored here
    assign w_fetch_ack = (r_state == S_FETCH) && imem_ack;
    // the cycle that would be the FETCH_TIMEOUT-th unacked one
    assign w_to_hit    = (r_state == S_FETCH) && !imem_ack
                         && (r_to == TO_LAST);

    always_comb begin
        w_legal   = 1'b0;
        w_is_halt = 1'b0;
        case (w_op)
            OP_LOADI,
            OP_ADD,
            OP_AND,
            OP_OR,
            OP_MOV,
            OP_SUB:  w_legal   = 1'b1;
            OP_HALT: w_is_halt = 1'b1;
            default: begin
                w_legal   = 1'b0;
                w_is_halt = 1'b0;
            end
        endcase
    end

    assign w_set_err = w_to_hit
                       || ((r_state == S_DECODE)
                           && !w_legal && !w_is_halt);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (run) w_next = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ack)      w_next = S_DECODE;
                else if (w_to_hit) w_next = S_HALT;
            end
            S_DECODE: begin
                w_next = w_legal ? S_EXEC : S_HALT;
            end
            S_EXEC: begin
                w_next = S_WB;
            end
            S_WB: begin
                w_next = run ? S_FETCH : S_IDLE;
            end
            S_HALT: begin
                w_next = S_HALT;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // state plus the strobes that are pure functions of the next state,
    // so every strobe is a flop output
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
            r_wen   <= 1'b0;
            r_halt  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_req   <= (w_next == S_FETCH);
            r_wen   <= (w_next == S_WB);
            r_halt  <= (w_next == S_HALT);
        end
    end

    // timeout counter restarts whenever FETCH is (re)entered
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_to <= '0;
        end else if (r_state != S_FETCH) begin
            r_to <= '0;
        end else if (!imem_ack && !w_to_hit) begin
            r_to <= r_to + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_instr <= 32'd0;
        end else if (w_fetch_ack) begin
            r_instr <= imem_rdata;
        end
    end

    // datapath controls captured once in DECODE, held through EXEC/WB
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_alu <= 3'd0;
            r_sub <= 1'b0;
            r_imm <= 1'b1;
        end else if ((r_state == S_DECODE) && w_legal) begin
            r_alu <= r_instr[26:24];
            r_sub <= (w_op == OP_SUB);
            r_imm <= (w_op != OP_LOADI);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err <= 1'b0;
        end else if (w_set_err) begin
            r_err <= 1'b1;
        end
    end

    // PC and retire count advance only on writeback; PC wraps mod 2^32
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc  <= RESET_PC;
            r_ret <= '0;
        end else if (r_state == S_WB) begin
            r_pc  <= r_pc + PC_STEP;
            r_ret <= r_ret + 1'b1;
        end
    end

    assign imem_addr = r_pc;
    assign imem_req  = r_req;
    assign instr     = r_instr;
    assign alu_sel   = r_alu;
    assign sub_en    = r_sub;
    assign imm_sel   = r_imm;
    assign rf_wen    = r_wen;
    assign halted    = r_halt;
    assign err       = r_err;
    assign retired   = r_ret;

endmodule

// File: tb/tb_instr_seq_ctrl.sv
// Bench for instr_seq_ctrl: directed and random programs against an
// instruction-level reference model with a wait-state memory responder.
module tb_instr_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [2:0]  alu_sel;
    logic        sub_en;
    logic        imm_sel;
    logic        rf_wen;
    logic        halted;
    logic        err;
    logic [15:0] retired;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    instr_seq_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .imem_addr  (imem_addr),
        .imem_req   (imem_req),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .instr      (instr),
        .alu_sel    (alu_sel),
        .sub_en     (sub_en),
        .imm_sel    (imm_sel),
        .rf_wen     (rf_wen),
        .halted     (halted),
        .err        (err),
        .retired    (retired)
    );

    logic [31:0] mem [256];
    int          waits [256];
    bit          resp_en = 1'b0;
    bit          force_ack = 1'b0;
    int          wcnt = 0;

    // memory: acks after waits[word] idle request cycles
    always @(negedge clk) begin
        imem_ack = 1'b0;
        if (force_ack) begin
            imem_ack   = 1'b1;
            imem_rdata = 32'h0100_0000;
        end else if (!imem_req) begin
            wcnt = 0;
        end else if (resp_en) begin
            if (wcnt >= waits[imem_addr[9:2]]) begin
                imem_ack   = 1'b1;
                imem_rdata = mem[imem_addr[9:2]];
            end else begin
                wcnt++;
            end
        end
    end

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        int          lat;
    } wb_t;

    wb_t         exp_q [$];
    logic [31:0] exp_pc;
    logic        exp_err;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) begin
            mem[i]   = 32'hFF00_0000;
            waits[i] = 0;
        end
    endtask

    task automatic do_reset();
        run   = 1'b0;
        reset = 1'b0;
        #2;
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_wen", {31'd0, rf_wen}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_alu", {29'd0, alu_sel}, 32'd0);
        chk("rst_sub", {31'd0, sub_en}, 32'd0);
        chk("rst_imm", {31'd0, imm_sel}, 32'd1);
        chk("rst_halt", {31'd0, halted}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_ret", {16'd0, retired}, 32'd0);
        tick();
        tick();
        reset = 1'b1;
    endtask

    // instruction-level model: walk the program from pc0 until halt
    task automatic model(input logic [31:0] pc0);
        logic [31:0] pc;
        logic [31:0] w;
        logic [7:0]  op;
        pc = pc0;
        exp_err = 1'b0;
        exp_q.delete();
        for (int n = 0; n < 256; n++) begin
            w  = mem[pc[9:2]];
            op = w[31:24];
            if (op inside {8'h00, 8'h01, 8'h02, 8'h03, 8'h08, 8'h09}) begin
                exp_q.push_back('{pc, w, 4 + waits[pc[9:2]]});
                pc = pc + 32'd4;
            end else begin
                exp_err = (op != 8'hFF);
                break;
            end
        end
        exp_pc = pc;
    endtask

    task automatic run_prog(input logic [31:0] pc0, input int ret0,
                            input int t0);
        int  last;
        int  n;
        bit  done;
        wb_t e;
        last = t0;
        n    = ret0;
        done = 1'b0;
        model(pc0);
        for (int k = 0; k < 3000 && !done; k++) begin
            tick();
            if (rf_wen) begin
                if (exp_q.size() == 0) begin
                    chk("extra_wen", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("wb_pc", imem_addr, e.pc);
                    chk("wb_instr", instr, e.ins);
                    chk("wb_alu", {29'd0, alu_sel}, {29'd0, e.ins[26:24]});
                    chk("wb_sub", {31'd0, sub_en},
                        {31'd0, e.ins[31:24] == 8'h09});
                    chk("wb_imm", {31'd0, imm_sel},
                        {31'd0, e.ins[31:24] != 8'h00});
                    chk("wb_lat", cyc - last, e.lat);
                    chk("wb_ret", {16'd0, retired}, n);
                    n++;
                    last = cyc;
                end
            end
            if (halted) done = 1'b1;
        end
        if (!done) chk("halt_budget", 32'd0, 32'd1);
        chk("left_wb", exp_q.size(), 32'd0);
        chk("halt_err", {31'd0, err}, {31'd0, exp_err});
        chk("halt_pc", imem_addr, exp_pc);
        chk("halt_req", {31'd0, imem_req}, 32'd0);
        chk("halt_wen", {31'd0, rf_wen}, 32'd0);
        chk("halt_ret", {16'd0, retired}, n);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int          reqc;
        logic [31:0] rr;
        logic [7:0]  b;
        logic [7:0]  legal [6];
        legal = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h08, 8'h09};

        clear_mem();
        tick();
        do_reset();

        // loadi r4,0xFF; loadi r6,0xAA; add r5,r6,r3; sub 4,7,3; halt
        mem[0] = 32'h0004_00FF;
        mem[1] = 32'h0006_00AA;
        mem[2] = 32'h0105_0603;
        mem[3] = 32'h0904_0F03;
        mem[4] = 32'hFF00_0000;
        resp_en = 1'b1;
        run = 1'b1;
        run_prog(32'd0, 0, cyc);

        // same program, second fetch acked 3 cycles late
        do_reset();
        waits[1] = 3;
        run = 1'b1;
        run_prog(32'd0, 0, cyc);

        // illegal opcode 0x05 at PC=8
        do_reset();
        clear_mem();
        mem[0] = 32'h0001_0012;
        mem[1] = 32'h0302_0100;
        mem[2] = 32'h0500_0000;
        run = 1'b1;
        run_prog(32'd0, 0, cyc);

        // fetch timeout: memory never answers
        do_reset();
        resp_en = 1'b0;
        run = 1'b1;
        reqc = 0;
        for (int k = 0; k < 40 && !halted; k++) begin
            tick();
            if (imem_req) reqc++;
        end
        chk("to_req_cycles", reqc, 32'd16);
        chk("to_err", {31'd0, err}, 32'd1);
        chk("to_halt", {31'd0, halted}, 32'd1);
        chk("to_req", {31'd0, imem_req}, 32'd0);
        chk("to_pc", imem_addr, 32'd0);
        do_reset();

        // reset mid-fetch, then a stray ack after release
        run = 1'b1;
        tick();
        tick();
        chk("mf_req_before", {31'd0, imem_req}, 32'd1);
        run = 1'b0;
        reset = 1'b0;
        #2;
        chk("mf_req_async", {31'd0, imem_req}, 32'd0);
        force_ack = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        tick();
        force_ack = 1'b0;
        tick();
        chk("mf_instr", instr, 32'd0);
        chk("mf_req", {31'd0, imem_req}, 32'd0);
        chk("mf_ret", {16'd0, retired}, 32'd0);
        chk("mf_halt", {31'd0, halted}, 32'd0);

        // run dropped during EXEC of the first instruction
        do_reset();
        clear_mem();
        mem[0] = 32'h0003_0007;
        mem[1] = 32'h0104_0300;
        mem[2] = 32'h0802_0400;
        mem[3] = 32'hFF00_0000;
        resp_en = 1'b1;
        run = 1'b1;
        tick();
        tick();
        tick();
        run = 1'b0;
        tick();
        chk("rd_wen", {31'd0, rf_wen}, 32'd1);
        chk("rd_wb_pc", imem_addr, 32'd0);
        tick();
        chk("rd_idle_req", {31'd0, imem_req}, 32'd0);
        chk("rd_idle_ret", {16'd0, retired}, 32'd1);
        chk("rd_idle_pc", imem_addr, 32'd4);
        tick();
        tick();
        chk("rd_hold_req", {31'd0, imem_req}, 32'd0);
        chk("rd_hold_pc", imem_addr, 32'd4);
        run = 1'b1;
        run_prog(32'd4, 1, cyc);

        // random programs with random wait states
        for (int r = 0; r < 8; r++) begin
            int nins;
            do_reset();
            clear_mem();
            nins = $urandom_range(3, 14);
            for (int i = 0; i < nins; i++) begin
                rr = $urandom();
                mem[i]   = {legal[$urandom_range(0, 5)], rr[23:0]};
                waits[i] = $urandom_range(0, 4);
            end
            if ($urandom_range(0, 1) == 0) begin
                mem[nins] = 32'hFF00_0000;
            end else begin
                do begin
                    rr = $urandom();
                    b  = rr[31:24];
                end while (b inside {8'h00, 8'h01, 8'h02, 8'h03,
                                     8'h08, 8'h09, 8'hFF});
                mem[nins] = {b, rr[23:0]};
            end
            waits[nins] = $urandom_range(0, 4);
            run = 1'b1;
            run_prog(32'd0, 0, cyc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
